// File: rtl/tri_raster_pkg.sv
// ---------------------------------------------------------------------------
// tri_raster_pkg
// Shared types and helpers for the triangle raster scanner:
//   int_point / int_triangle : signed integer vertex types
//   acc_t                    : edge-function accumulator (2*COORD_W+2 bits)
//   scan_state_e             : scanner FSM states
//   edge_fn                  : direct edge-function evaluation
// Screen size defaults also live here.
// ---------------------------------------------------------------------------
package tri_raster_pkg;

  localparam int PKG_COORD_W  = 16;
  localparam int PKG_ACC_W    = 2 * PKG_COORD_W + 2;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef logic signed [PKG_ACC_W-1:0] acc_t;

  typedef struct packed {
    logic signed [PKG_COORD_W-1:0] x;
    logic signed [PKG_COORD_W-1:0] y;
  } int_point;

  typedef struct packed {
    int_point a;
    int_point b;
    int_point c;
  } int_triangle;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2
  } scan_state_e;

  // e(a,b,p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x)
  function automatic acc_t edge_fn(input int_point a, input int_point b, input int_point p);
    acc_t bax;
    acc_t bay;
    acc_t pax;
    acc_t pay;
    bax = acc_t'($signed(b.x)) - acc_t'($signed(a.x));
    bay = acc_t'($signed(b.y)) - acc_t'($signed(a.y));
    pax = acc_t'($signed(p.x)) - acc_t'($signed(a.x));
    pay = acc_t'($signed(p.y)) - acc_t'($signed(a.y));
    return (bax * pay) - (bay * pax);
  endfunction

endpackage

// File: rtl/tri_raster_scanner_setup.sv
// ---------------------------------------------------------------------------
// tri_edge_setup
// Purely combinational triangle setup, evaluated during the SETUP cycle.
//   vtx              : registered triangle (a, b, c)
//   xmin/xmax/ymin/ymax : bounding box clamped to the screen
//   e_init[3]        : edge values e(a,b), e(b,c), e(c,a) at (xmin,ymin)
//   dx[3] / dy[3]    : edge increments for a +1 step in x / in y
//   cull             : nothing to draw (abc<=0 or box entirely off-screen)
// Optional feature: TRI_RASTER_TWO_SIDED_EN -- back-facing (abc<0) triangles
// are flipped (abc and all edge terms negated) instead of culled.
// ---------------------------------------------------------------------------
module tri_edge_setup
  import tri_raster_pkg::*;
#(
  parameter int COORD_W  = PKG_COORD_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ACC_W    = 2 * COORD_W + 2
) (
  input  int_triangle                vtx,
  output logic        [COORD_W-1:0]  xmin,
  output logic        [COORD_W-1:0]  xmax,
  output logic        [COORD_W-1:0]  ymin,
  output logic        [COORD_W-1:0]  ymax,
  output logic signed [ACC_W-1:0]    e_init [3],
  output logic signed [ACC_W-1:0]    dx [3],
  output logic signed [ACC_W-1:0]    dy [3],
  output logic                       cull
);

  typedef logic signed [ACC_W-1:0] sacc_t;

  localparam logic signed [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 32'sd1);
  localparam logic signed [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 32'sd1);

  function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] p,
                                                     input logic signed [COORD_W-1:0] q,
                                                     input logic signed [COORD_W-1:0] r);
    logic signed [COORD_W-1:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] p,
                                                     input logic signed [COORD_W-1:0] q,
                                                     input logic signed [COORD_W-1:0] r);
    logic signed [COORD_W-1:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  logic signed [COORD_W-1:0] lo_x_s;
  logic signed [COORD_W-1:0] hi_x_s;
  logic signed [COORD_W-1:0] lo_y_s;
  logic signed [COORD_W-1:0] hi_y_s;
  logic                      empty_s;
  logic                      flip_s;
  int_point                  corner_s;
  sacc_t                     abc_raw_s;
  sacc_t                     abc_eff_s;
  sacc_t                     e_raw_s  [3];
  sacc_t                     dx_raw_s [3];
  sacc_t                     dy_raw_s [3];

  // Bounding box: emptiness is judged on the raw extents, because clamping an
  // all-off-screen box would otherwise collapse it onto the screen border.
  always_comb begin
    lo_x_s  = min3(vtx.a.x, vtx.b.x, vtx.c.x);
    hi_x_s  = max3(vtx.a.x, vtx.b.x, vtx.c.x);
    lo_y_s  = min3(vtx.a.y, vtx.b.y, vtx.c.y);
    hi_y_s  = max3(vtx.a.y, vtx.b.y, vtx.c.y);
    empty_s = hi_x_s[COORD_W-1] || (lo_x_s > X_LAST) ||
              hi_y_s[COORD_W-1] || (lo_y_s > Y_LAST);
    xmin    = lo_x_s[COORD_W-1] ? '0 : lo_x_s;
    ymin    = lo_y_s[COORD_W-1] ? '0 : lo_y_s;
    xmax    = (hi_x_s > X_LAST) ? X_LAST : hi_x_s;
    ymax    = (hi_y_s > Y_LAST) ? Y_LAST : hi_y_s;
  end

  // Edge values at the box corner, area term, per-step increments, orientation fix-up.
  always_comb begin
    corner_s    = '0;
    corner_s.x  = xmin;
    corner_s.y  = ymin;
    abc_raw_s   = edge_fn(vtx.a, vtx.b, vtx.c);
    e_raw_s[0]  = edge_fn(vtx.a, vtx.b, corner_s);
    e_raw_s[1]  = edge_fn(vtx.b, vtx.c, corner_s);
    e_raw_s[2]  = edge_fn(vtx.c, vtx.a, corner_s);
    // e(s,t,p) grows by (s.y - t.y) per +1 in x and by (t.x - s.x) per +1 in y
    dx_raw_s[0] = sacc_t'($signed(vtx.a.y)) - sacc_t'($signed(vtx.b.y));
    dy_raw_s[0] = sacc_t'($signed(vtx.b.x)) - sacc_t'($signed(vtx.a.x));
    dx_raw_s[1] = sacc_t'($signed(vtx.b.y)) - sacc_t'($signed(vtx.c.y));
    dy_raw_s[1] = sacc_t'($signed(vtx.c.x)) - sacc_t'($signed(vtx.b.x));
    dx_raw_s[2] = sacc_t'($signed(vtx.c.y)) - sacc_t'($signed(vtx.a.y));
    dy_raw_s[2] = sacc_t'($signed(vtx.a.x)) - sacc_t'($signed(vtx.c.x));
`ifdef TRI_RASTER_TWO_SIDED_EN
    flip_s      = abc_raw_s[ACC_W-1];
`else
    flip_s      = 1'b0;
`endif
    abc_eff_s   = flip_s ? -abc_raw_s : abc_raw_s;
    for (int i = 0; i < 3; i++) begin
      e_init[i] = flip_s ? -e_raw_s[i]  : e_raw_s[i];
      dx[i]     = flip_s ? -dx_raw_s[i] : dx_raw_s[i];
      dy[i]     = flip_s ? -dy_raw_s[i] : dy_raw_s[i];
    end
    cull        = empty_s || abc_eff_s[ACC_W-1] || (abc_eff_s == '0);
  end

endmodule

// File: rtl/tri_raster_scanner.sv
// ---------------------------------------------------------------------------
// tri_raster_scanner
// Scans the clamped bounding box of one triangle in raster order and emits
// every pixel whose three edge functions are non-negative.
// Ports:
//   clk, rst (async, active high)
//   tri_valid / tri_ready / in_tri         : triangle input handshake
//   frag_valid / frag_ready / frag_x/_y    : fragment output handshake
//   busy                                   : FSM not idle
//   done                                   : one-cycle pulse at completion
// Optional feature: TRI_RASTER_TWO_SIDED_EN (rasterise back-facing triangles).
// ---------------------------------------------------------------------------
module tri_raster_scanner
  import tri_raster_pkg::*;
#(
  parameter int COORD_W  = PKG_COORD_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  int_triangle        in_tri,
  output logic               frag_valid,
  input  logic               frag_ready,
  output logic [COORD_W-1:0] frag_x,
  output logic [COORD_W-1:0] frag_y,
  output logic               busy,
  output logic               done
);

  localparam int ACC_W = 2 * COORD_W + 2;
  typedef logic signed [ACC_W-1:0] sacc_t;
  localparam logic [COORD_W-1:0] ONE_C = COORD_W'(32'd1);

  scan_state_e        state_r;
  scan_state_e        state_next_s;
  int_triangle        tri_r;
  logic [COORD_W-1:0] xmin_r, xmax_r, ymax_r, cur_x_r, cur_y_r;
  logic [COORD_W-1:0] frag_x_r, frag_y_r;
  sacc_t              e_r [3];
  sacc_t              row_e_r [3];
  sacc_t              dx_r [3];
  sacc_t              dy_r [3];
  logic               scan_last_r, frag_valid_r, done_r, busy_r, tri_ready_r;

  logic [COORD_W-1:0] su_xmin_s, su_xmax_s, su_ymin_s, su_ymax_s;
  sacc_t              su_e_s  [3];
  sacc_t              su_dx_s [3];
  sacc_t              su_dy_s [3];
  logic               su_cull_s;
  logic               accept_s, slot_free_s, inside_s, row_end_s, last_px_s, done_next_s;

  tri_edge_setup #(
    .COORD_W  (COORD_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ACC_W    (ACC_W)
  ) u_setup (
    .vtx    (tri_r),
    .xmin   (su_xmin_s),
    .xmax   (su_xmax_s),
    .ymin   (su_ymin_s),
    .ymax   (su_ymax_s),
    .e_init (su_e_s),
    .dx     (su_dx_s),
    .dy     (su_dy_s),
    .cull   (su_cull_s)
  );

  // Handshake and pixel-position decode. abc>0 is guaranteed by setup culling,
  // so the inside test only needs the three edge signs.
  always_comb begin
    accept_s    = tri_valid && tri_ready_r;
    slot_free_s = !frag_valid_r || frag_ready;
    inside_s    = !e_r[0][ACC_W-1] && !e_r[1][ACC_W-1] && !e_r[2][ACC_W-1];
    row_end_s   = (cur_x_r == xmax_r);
    last_px_s   = row_end_s && (cur_y_r == ymax_r);
  end

  // Next-state logic and completion pulse request.
  always_comb begin
    state_next_s = state_r;
    done_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (su_cull_s) begin
          state_next_s = ST_IDLE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Finish once the final fragment drains, or straight away when the
        // final pixel is outside and the output slot is free.
        if (slot_free_s && (scan_last_r || (last_px_s && !inside_s))) begin
          state_next_s = ST_IDLE;
          done_next_s  = 1'b1;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      tri_ready_r <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      done_r      <= done_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
      tri_ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Triangle capture, setup load, raster walk and fragment output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_r        <= '0;
      xmin_r       <= '0;
      xmax_r       <= '0;
      ymax_r       <= '0;
      cur_x_r      <= '0;
      cur_y_r      <= '0;
      scan_last_r  <= 1'b0;
      frag_valid_r <= 1'b0;
      frag_x_r     <= '0;
      frag_y_r     <= '0;
      for (int i = 0; i < 3; i++) begin
        e_r[i]     <= '0;
        row_e_r[i] <= '0;
        dx_r[i]    <= '0;
        dy_r[i]    <= '0;
      end
    end else begin
      if (accept_s) begin
        tri_r <= in_tri;
      end
      case (state_r)
        ST_SETUP: begin
          xmin_r       <= su_xmin_s;
          xmax_r       <= su_xmax_s;
          ymax_r       <= su_ymax_s;
          cur_x_r      <= su_xmin_s;
          cur_y_r      <= su_ymin_s;
          scan_last_r  <= 1'b0;
          frag_valid_r <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            e_r[i]     <= su_e_s[i];
            row_e_r[i] <= su_e_s[i];
            dx_r[i]    <= su_dx_s[i];
            dy_r[i]    <= su_dy_s[i];
          end
        end
        ST_SCAN: begin
          if (slot_free_s) begin
            if (scan_last_r) begin
              frag_valid_r <= 1'b0;
            end else begin
              frag_valid_r <= inside_s;
              if (inside_s) begin
                frag_x_r <= cur_x_r;
                frag_y_r <= cur_y_r;
              end
              if (row_end_s) begin
                if (last_px_s) begin
                  scan_last_r <= 1'b1;
                end else begin
                  cur_x_r <= xmin_r;
                  cur_y_r <= cur_y_r + ONE_C;
                  for (int i = 0; i < 3; i++) begin
                    row_e_r[i] <= row_e_r[i] + dy_r[i];
                    e_r[i]     <= row_e_r[i] + dy_r[i];
                  end
                end
              end else begin
                cur_x_r <= cur_x_r + ONE_C;
                for (int i = 0; i < 3; i++) begin
                  e_r[i] <= e_r[i] + dx_r[i];
                end
              end
            end
          end
        end
        default: begin
          frag_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign tri_ready  = tri_ready_r;
  assign frag_valid = frag_valid_r;
  assign frag_x     = frag_x_r;
  assign frag_y     = frag_y_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_tri_raster_scanner.sv
module tb_tri_raster_scanner;
  import tri_raster_pkg::*;

  localparam int SW = DEF_SCREEN_W;
  localparam int SH = DEF_SCREEN_H;

  logic        clk, rst, tri_valid, tri_ready, frag_valid, frag_ready, busy, done;
  int_triangle in_tri;
  logic [15:0] frag_x, frag_y;

  int          n_tests, n_fail, frag_cnt, done_cnt, stall_idx, stall_used;
  logic [31:0] exp_q [$];

  tri_raster_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .in_tri     (in_tri),
    .frag_valid (frag_valid),
    .frag_ready (frag_ready),
    .frag_x     (frag_x),
    .frag_y     (frag_y),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint ef(input longint ax, input longint ay, input longint bx,
                                input longint by, input longint px, input longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic int min3i(input int p, input int q, input int r);
    int m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic int max3i(input int p, input int q, input int r);
    int m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  // Reference model: direct edge evaluation over the clamped box, pushes expected pixels.
  task automatic model_push(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy, output int n);
    longint abc, e0, e1, e2;
    bit     flip;
    int     lx, hx, ly, hy;
    n    = 0;
    flip = 1'b0;
    abc  = ef(ax, ay, bx, by, cx, cy);
`ifdef TRI_RASTER_TWO_SIDED_EN
    if (abc < 0) flip = 1'b1;
`endif
    if (flip) abc = -abc;
    if (abc <= 0) return;
    lx = min3i(ax, bx, cx); hx = max3i(ax, bx, cx);
    ly = min3i(ay, by, cy); hy = max3i(ay, by, cy);
    if (hx < 0 || lx > SW - 1 || hy < 0 || ly > SH - 1) return;
    if (lx < 0) lx = 0;
    if (ly < 0) ly = 0;
    if (hx > SW - 1) hx = SW - 1;
    if (hy > SH - 1) hy = SH - 1;
    for (int y = ly; y <= hy; y++) begin
      for (int x = lx; x <= hx; x++) begin
        e0 = ef(ax, ay, bx, by, x, y);
        e1 = ef(bx, by, cx, cy, x, y);
        e2 = ef(cx, cy, ax, ay, x, y);
        if (flip) begin e0 = -e0; e1 = -e1; e2 = -e2; end
        if (e0 >= 0 && e1 >= 0 && e2 >= 0) begin
          exp_q.push_back({16'(x), 16'(y)});
          n++;
        end
      end
    end
  endtask

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic drive_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, output bit ok);
    in_tri.a.x = 16'(ax); in_tri.a.y = 16'(ay);
    in_tri.b.x = 16'(bx); in_tri.b.y = 16'(by);
    in_tri.c.x = 16'(cx); in_tri.c.y = 16'(cy);
    tri_valid  = 1'b1;
    for (int k = 0; k < 100 && !tri_ready; k++) @(negedge clk);
    if (!tri_ready) begin
      check("accept_timeout", 64'(tri_ready), 64'd1);
      tri_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      #1 tri_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic run_tri(input string name, input int ax, input int ay, input int bx,
                         input int by, input int cx, input int cy, input int cnt_const,
                         input int exp_lat, input bit b2b);
    int n_exp, base, dbase, lat;
    bit ok, seen;
    model_push(ax, ay, bx, by, cx, cy, n_exp);
    base  = frag_cnt;
    dbase = done_cnt;
    drive_tri(ax, ay, bx, by, cx, cy, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({name, "_busy1"}, {62'd0, busy, tri_ready}, 64'd2);
        check({name, "_nofrag1"}, 64'(frag_valid), 64'd0);
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check({name, "_done_timeout"}, 64'(seen), 64'd1);
      exp_q.delete();
    end else begin
      check({name, "_nfrag"}, 64'(frag_cnt - base), 64'(n_exp));
      if (cnt_const >= 0) check({name, "_count"}, 64'(frag_cnt - base), 64'(cnt_const));
      check({name, "_idle_at_done"}, {62'd0, busy, tri_ready}, 64'd1);
      if (exp_lat >= 0) check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      if (!b2b) begin
        @(negedge clk);
        check({name, "_pulse"}, 64'(done), 64'd0);
        check({name, "_ndone"}, 64'(done_cnt - dbase), 64'd1);
      end
    end
  endtask

  initial begin
    int  n, base;
    bit  ok;
    n_tests = 0; n_fail = 0; frag_cnt = 0; done_cnt = 0;
    stall_idx = -1; stall_used = 0;
    rst = 1'b1; tri_valid = 1'b0; frag_ready = 1'b1; in_tri = '0;

    // Output monitor: drives frag_ready, scores fragments, counts done pulses.
    fork
      forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (frag_valid && frag_cnt == stall_idx && stall_used < 3) begin
          frag_ready = 1'b0;
          stall_used++;
        end else begin
          frag_ready = 1'b1;
          if (frag_cnt != stall_idx) stall_used = 0;
        end
        if (frag_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frag", 64'(exp_q.size()), 64'd1);
          end else if (frag_ready) begin
            check("frag_xy", {32'd0, frag_x, frag_y}, {32'd0, exp_q.pop_front()});
            frag_cnt++;
          end else begin
            check("held_xy", {32'd0, frag_x, frag_y}, {32'd0, exp_q[0]});
          end
        end
      end
    join_none

    @(negedge clk);
    check("rst_outputs", {58'd0, tri_ready, busy, frag_valid, done, 2'd0}, 64'h20);
    check("rst_xy", {32'd0, frag_x, frag_y}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_tri("basic",     0, 0, 4, 0, 0, 4, 15, -1, 1'b0);
`ifdef TRI_RASTER_TWO_SIDED_EN
    run_tri("reversed",  0, 0, 0, 4, 4, 0, 15, -1, 1'b0);
`else
    run_tri("reversed",  0, 0, 0, 4, 4, 0, 0, 2, 1'b0);
`endif
    run_tri("collinear", 0, 0, 2, 2, 4, 4, 0, 2, 1'b0);
    run_tri("clipped", -10, -10, 20, -10, -10, 20, 66, -1, 1'b0);
    run_tri("offscreen", 700, 10, 710, 10, 700, 20, 0, 2, 1'b0);

    stall_idx = frag_cnt + 1;
    run_tri("stall",     0, 0, 4, 0, 0, 4, 15, -1, 1'b0);
    stall_idx = -1;

    run_tri("b2b_first", 0, 0, 4, 0, 0, 4, 15, -1, 1'b1);
    run_tri("b2b_second", 2, 1, 9, 3, 4, 8, -1, -1, 1'b0);

    // Reset in the middle of a scan
    model_push(0, 0, 4, 0, 0, 4, n);
    base = frag_cnt;
    drive_tri(0, 0, 4, 0, 0, 4, ok);
    for (int k = 0; k < 200 && frag_cnt < base + 5; k++) @(negedge clk);
    check("rst_reach5", 64'(frag_cnt >= base + 5), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {58'd0, tri_ready, busy, frag_valid, done, 2'd0}, 64'h20);
    check("midrst_xy", {32'd0, frag_x, frag_y}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_tri("after_rst", 0, 0, 4, 0, 0, 4, 15, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
